// File: rtl/video_timing_pkg.sv
// video_timing_pkg: 720p timing defaults, pattern mode encoding and colour-bar palette
package video_timing_pkg;
    localparam int VT_H_ACTIVE = 1280;
    localparam int VT_H_FP     = 110;
    localparam int VT_H_SYNC   = 40;
    localparam int VT_H_BP     = 220;
    localparam int VT_V_ACTIVE = 720;
    localparam int VT_V_FP     = 5;
    localparam int VT_V_SYNC   = 5;
    localparam int VT_V_BP     = 20;
    localparam int CNT_W       = 12;

    typedef enum logic [1:0] {MODE_BARS, MODE_RAMP, MODE_CHECK, MODE_SOLID} mode_e;
    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    // Index 0 is the leftmost bar.
    localparam logic [0:7][23:0] BAR_PAL = {
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };
endpackage

// File: rtl/video_pattern_gen_if.sv
// video_pattern_gen_if: registered pixel stream (valid, syncs, start-of-frame, RGB)
interface video_pattern_gen_if;
    logic       dv;
    logic       hs;
    logic       vs;
    logic       sof;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    modport master (output dv, hs, vs, sof, r, g, b);
    modport slave  (input  dv, hs, vs, sof, r, g, b);
endinterface

// File: rtl/video_timing_counter.sv
// video_timing_counter: raster counters, IDLE/RUN control and active/sync window flags
module video_timing_counter
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = VT_H_ACTIVE,
    parameter int H_FP     = VT_H_FP,
    parameter int H_SYNC   = VT_H_SYNC,
    parameter int H_BP     = VT_H_BP,
    parameter int V_ACTIVE = VT_V_ACTIVE,
    parameter int V_FP     = VT_V_FP,
    parameter int V_SYNC   = VT_V_SYNC,
    parameter int V_BP     = VT_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] hcnt_o,
    output logic [CNT_W-1:0] vcnt_o,
    output logic             run_o,
    output logic             active_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             line_end_o,
    output logic             frame_wrap_o,
    output logic             load_o
);
    localparam logic [CNT_W-1:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic             v_end;

    always_comb begin
        run_o        = state_q == ST_RUN;
        line_end_o   = hcnt_q == H_LAST;
        v_end        = vcnt_q == V_LAST;
        frame_wrap_o = run_o && line_end_o && v_end;
        load_o       = (!run_o && en_i) || frame_wrap_o;
        // Leaving RUN is only allowed at the frame wrap so frames are never cut short.
        state_d      = run_o ? ((frame_wrap_o && !en_i) ? ST_IDLE : ST_RUN)
                             : (en_i ? ST_RUN : ST_IDLE);
        hcnt_d       = (!run_o || line_end_o) ? '0 : hcnt_q + 1'b1;
        vcnt_d       = !run_o ? '0 : line_end_o ? (v_end ? '0 : vcnt_q + 1'b1) : vcnt_q;
        active_o     = run_o && hcnt_q < H_ACT && vcnt_q < V_ACT;
        hsync_o      = run_o && hcnt_q >= HS_START && hcnt_q < HS_END;
        vsync_o      = run_o && vcnt_q >= VS_START && vcnt_q < VS_END;
        hcnt_o       = hcnt_q;
        vcnt_o       = vcnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end
endmodule

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster test-pattern source (bars, ramp, checkerboard, solid)
// with a single registered output stage aligning valid, syncs, sof and RGB.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VT_H_ACTIVE,
    parameter int   H_FP     = VT_H_FP,
    parameter int   H_SYNC   = VT_H_SYNC,
    parameter int   H_BP     = VT_H_BP,
    parameter int   V_ACTIVE = VT_V_ACTIVE,
    parameter int   V_FP     = VT_V_FP,
    parameter int   V_SYNC   = VT_V_SYNC,
    parameter int   V_BP     = VT_V_BP,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic [1:0]          mode_i,
    input  logic [23:0]         solid_i,
    video_pattern_gen_if.master pix,
    output logic [15:0]         frame_cnt_o
);
    localparam logic [CNT_W-1:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             run, active, hsync, vsync, line_end, frame_wrap, load;
    mode_e            mode_q, mode_d;
    logic [23:0]      solid_q, solid_d, rgb_q, rgb_d, pat;
    logic [CNT_W-1:0] bar_px_q, bar_px_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic             bar_step;
    logic             dv_q, dv_d, hs_q, hs_d, vs_q, vs_d, sof_q, sof_d;
    logic [15:0]      fcnt_q, fcnt_d;

    video_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .rst(rst), .en_i(en_i),
        .hcnt_o(hcnt), .vcnt_o(vcnt), .run_o(run), .active_o(active),
        .hsync_o(hsync), .vsync_o(vsync), .line_end_o(line_end),
        .frame_wrap_o(frame_wrap), .load_o(load)
    );

    always_comb begin
        mode_d    = load ? mode_e'(mode_i) : mode_q;
        solid_d   = load ? solid_i : solid_q;
        // Bar position tracks hcnt; the last bar absorbs any remainder pixels.
        bar_step  = bar_idx_q != 3'd7 && bar_px_q == BAR_LAST;
        bar_px_d  = (!run || line_end || bar_step) ? '0
                  : (bar_idx_q == 3'd7 ? bar_px_q : bar_px_q + 1'b1);
        bar_idx_d = (!run || line_end) ? '0 : (bar_step ? bar_idx_q + 1'b1 : bar_idx_q);
        pat       = mode_q == MODE_BARS  ? BAR_PAL[bar_idx_q]
                  : mode_q == MODE_RAMP  ? {3{hcnt[7:0]}}
                  : mode_q == MODE_CHECK ? {24{hcnt[5] ^ vcnt[5]}}
                  : solid_q;
        dv_d      = active;
        rgb_d     = active ? pat : '0;
        hs_d      = hsync ? HS_POL : ~HS_POL;
        vs_d      = vsync ? VS_POL : ~VS_POL;
        sof_d     = active && hcnt == '0 && vcnt == '0;
        fcnt_d    = fcnt_q + 16'(frame_wrap);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_BARS;
            solid_q   <= '0;
            bar_px_q  <= '0;
            bar_idx_q <= '0;
            dv_q      <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            sof_q     <= 1'b0;
            rgb_q     <= '0;
            fcnt_q    <= '0;
        end else begin
            mode_q    <= mode_d;
            solid_q   <= solid_d;
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            dv_q      <= dv_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            sof_q     <= sof_d;
            rgb_q     <= rgb_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign pix.dv      = dv_q;
    assign pix.hs      = hs_q;
    assign pix.vs      = vs_q;
    assign pix.sof     = sof_q;
    assign pix.r       = rgb_q[23:16];
    assign pix.g       = rgb_q[15:8];
    assign pix.b       = rgb_q[7:0];
    assign frame_cnt_o = fcnt_q;
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: two small rasters (16x8 and 64x64) driven together and
// compared every cycle against a linear-position reference model, plus directed checks.
module tb_video_pattern_gen;
    localparam int HF = 2, HSW = 3, HB = 3, VF = 1, VSW = 2, VB = 1;
    localparam int HA [2] = '{16, 64};
    localparam int VA [2] = '{8, 64};
    localparam logic [27:0] IDLE_PIX = 28'h0;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] solid = 24'h0;
    logic [15:0] fc0, fc1;
    int          n_tests = 0, n_fail = 0;

    video_pattern_gen_if pix0 ();
    video_pattern_gen_if pix1 ();

    video_pattern_gen #(
        .H_ACTIVE(16), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(8), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut0 (.clk(clk), .rst(rst), .en_i(en), .mode_i(mode), .solid_i(solid), .pix(pix0), .frame_cnt_o(fc0));

    video_pattern_gen #(
        .H_ACTIVE(64), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(64), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut1 (.clk(clk), .rst(rst), .en_i(en), .mode_i(mode), .solid_i(solid), .pix(pix1), .frame_cnt_o(fc1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int frame_len(input int k);
        return (HA[k] + HF + HSW + HB) * (VA[k] + VF + VSW + VB);
    endfunction

    // Expected {dv,hs,vs,sof,rgb} for linear position p within the frame.
    function automatic logic [27:0] ref_pix(input int k, input int p, input logic [1:0] md, input logic [23:0] sc);
        int ht, x, y, bar;
        bit act, hs, vs;
        logic [23:0] c;
        ht  = HA[k] + HF + HSW + HB;
        x   = p % ht;
        y   = p / ht;
        act = x < HA[k] && y < VA[k];
        hs  = x >= HA[k] + HF && x < HA[k] + HF + HSW;
        vs  = y >= VA[k] + VF && y < VA[k] + VF + VSW;
        bar = x / (HA[k] / 8);
        if (bar > 7) bar = 7;
        case (md)
            2'd0: c = {(bar < 2 || bar == 4 || bar == 5) ? 8'hFF : 8'h00,
                       (bar < 4) ? 8'hFF : 8'h00,
                       (bar % 2 == 0) ? 8'hFF : 8'h00};
            2'd1: c = {3{8'(x % 256)}};
            2'd2: c = (((x / 32) + (y / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
            default: c = sc;
        endcase
        return {act, hs, vs, act && p == 0, act ? c : 24'h0};
    endfunction

    bit          m_run   [2] = '{0, 0};
    int          m_p     [2] = '{0, 0};
    logic [1:0]  m_mode  [2] = '{2'd0, 2'd0};
    logic [23:0] m_solid [2] = '{24'h0, 24'h0};
    logic [15:0] m_fc    [2] = '{16'h0, 16'h0};
    logic [27:0] e_pix   [2] = '{28'h0, 28'h0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_run[k] <= 1'b0; m_p[k] <= 0; m_mode[k] <= 2'd0;
                m_solid[k] <= 24'h0; m_fc[k] <= 16'h0; e_pix[k] <= IDLE_PIX;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                e_pix[k] <= m_run[k] ? ref_pix(k, m_p[k], m_mode[k], m_solid[k]) : IDLE_PIX;
                if (!m_run[k]) begin
                    if (en) begin
                        m_run[k] <= 1'b1; m_p[k] <= 0; m_mode[k] <= mode; m_solid[k] <= solid;
                    end
                end else if (m_p[k] == frame_len(k) - 1) begin
                    m_p[k] <= 0; m_fc[k] <= m_fc[k] + 16'd1;
                    m_mode[k] <= mode; m_solid[k] <= solid; m_run[k] <= en;
                end else begin
                    m_p[k] <= m_p[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("pix0", 32'({pix0.dv, pix0.hs, pix0.vs, pix0.sof, pix0.r, pix0.g, pix0.b}), 32'(e_pix[0]));
        check("pix1", 32'({pix1.dv, pix1.hs, pix1.vs, pix1.sof, pix1.r, pix1.g, pix1.b}), 32'(e_pix[1]));
        check("fcnt0", 32'(fc0), 32'(m_fc[0]));
        check("fcnt1", 32'(fc1), 32'(m_fc[1]));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_sof();
        int n = 0;
        while (pix0.sof !== 1'b1 && n < 600) begin
            tick(1);
            n++;
        end
        check("sof_wait", 32'(pix0.sof), 32'd1);
    endtask

    initial begin
        int n, dvn;
        logic [15:0] f0;
        logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        en = 1'b1;
        tick(3);
        check("rst_pix", 32'({pix0.dv, pix0.hs, pix0.vs, pix0.sof, pix0.r, pix0.g, pix0.b}), 32'd0);
        check("rst_fc", 32'(fc0), 32'd0);
        rst = 1'b0;
        tick(1);
        check("sof_edge1", 32'(pix0.sof), 32'd0);
        tick(1);
        check("sof_edge2", 32'(pix0.sof), 32'd1);
        check("dv_first", 32'(pix0.dv), 32'd1);
        for (int x = 0; x < 16; x++) begin
            check("bar_px", 32'({pix0.r, pix0.g, pix0.b}), 32'(bars[x / 2]));
            tick(1);
        end
        check("blank_rgb", 32'({pix0.dv, pix0.r, pix0.g, pix0.b}), 32'd0);
        n = 16;
        while (pix0.sof !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        check("frame_len", 32'(n), 32'd288);
        tick(18);
        check("hs_start", 32'(pix0.hs), 32'd1);
        tick(2);
        check("hs_last", 32'(pix0.hs), 32'd1);
        tick(1);
        check("hs_end", 32'(pix0.hs), 32'd0);

        repeat (8) begin
            tick($urandom_range(20, 300));
            mode  = 2'($urandom_range(0, 3));
            solid = 24'($urandom);
        end

        mode = 2'd1;
        tick(300);
        wait_sof();
        tick(10);
        mode  = 2'd3;
        solid = 24'h123456;
        tick(14);
        for (int x = 0; x < 16; x++) begin
            check("ramp_hold", 32'({pix0.r, pix0.g, pix0.b}), 32'({3{8'(x)}}));
            tick(1);
        end
        wait_sof();
        check("solid_next", 32'({pix0.r, pix0.g, pix0.b}), 32'h123456);

        f0 = fc0; n = 0; dvn = 0;
        while (fc0 == f0 && n < 400) begin
            dvn += int'(pix0.dv);
            if (n == 72) en = 1'b0;
            tick(1);
            n++;
        end
        check("drop_fc", 32'(fc0), 32'(f0 + 16'd1));
        check("drop_dv", 32'(dvn), 32'd128);
        tick(20);
        check("idle_dvhsvs", 32'({pix0.dv, pix0.hs, pix0.vs}), 32'd0);
        tick(300);
        check("idle_fc", 32'(fc0), 32'(f0 + 16'd1));

        en = 1'b1;
        wait_sof();
        tick(5 * 24 + 3);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async0", 32'({pix0.dv, pix0.hs, pix0.vs, pix0.sof, pix0.r, pix0.g, pix0.b}), 32'd0);
        check("rst_async1", 32'({pix1.dv, pix1.hs, pix1.vs, pix1.sof, pix1.r, pix1.g, pix1.b}), 32'd0);
        check("rst_async_fc", 32'(fc0), 32'd0);
        mode  = 2'd2;
        solid = 24'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        check("restart_edge1", 32'(pix0.sof), 32'd0);
        tick(1);
        check("restart_sof0", 32'(pix0.sof), 32'd1);
        check("restart_sof1", 32'(pix1.sof), 32'd1);
        check("cb_0_0", 32'({pix1.r, pix1.g, pix1.b}), 32'h000000);
        tick(32);
        check("cb_32_0", 32'({pix1.r, pix1.g, pix1.b}), 32'hFFFFFF);
        tick(32 * 72);
        check("cb_32_32", 32'({pix1.r, pix1.g, pix1.b}), 32'h000000);
        tick(frame_len(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
